free_list: RTL

Physical-register free pool for the rename stage. It hands out up to two free physical registers per cycle to rename, for new destination mappings. It takes back up to two retired registers per cycle from the ROB (`freeRegStruct`, the old `rd_old` mappings) and recycles them. It sits between ROB retire (upstream of the free path) and rename/dispatch (downstream consumer of allocations). Internally it is a 2-wide-in, 2-wide-out circular FIFO of physical register numbers.

---
 rtl/free_list_pkg.sv | 17 +
 rtl/free_list.sv | 106 ++++++++++
 2 files changed

// File: rtl/free_list_pkg.sv
// Shared sizing constants and the retire-free payload for the rename free pool.
package free_list_pkg;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned PREG_BITS = 6;
  localparam int unsigned FL_DEPTH  = NUM_PREGS - NUM_AREGS;

  // Up to two old rd mappings released by ROB retire in one cycle.
  typedef struct packed {
    logic                 valid1;
    logic [PREG_BITS-1:0] reg1;
    logic                 valid2;
    logic [PREG_BITS-1:0] reg2;
  } freeRegStruct;

endpackage

// File: rtl/free_list.sv
// Physical-register free pool: 2-wide circular FIFO feeding rename, refilled by retire.
module free_list
  import free_list_pkg::*;
#(
  parameter int unsigned NUM_PREGS = free_list_pkg::NUM_PREGS,
  parameter int unsigned NUM_AREGS = free_list_pkg::NUM_AREGS,
  parameter int unsigned PREG_BITS = free_list_pkg::PREG_BITS,
  parameter int unsigned FL_DEPTH  = free_list_pkg::FL_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_req_a,
  input  logic                          alloc_req_b,
  output logic [PREG_BITS-1:0]          alloc_reg_a,
  output logic [PREG_BITS-1:0]          alloc_reg_b,
  output logic                          alloc_ok,
  input  freeRegStruct                  free_in,
  output logic [$clog2(FL_DEPTH+1)-1:0] free_count
);

  localparam int unsigned PTR_W = $clog2(FL_DEPTH);
  localparam int unsigned CNT_W = $clog2(FL_DEPTH + 1);

  logic [PREG_BITS-1:0] fifo [FL_DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  logic [1:0]           n_req;
  logic [1:0]           n_free;
  logic                 grant;
  logic                 acc1;
  logic                 acc2;
  logic                 wr0_en;
  logic                 wr1_en;
  logic [PREG_BITS-1:0] wr0_reg;
  logic [PTR_W-1:0]     head_p1;
  logic [PTR_W-1:0]     tail_p1;
  logic [PTR_W-1:0]     head_next;
  logic [PTR_W-1:0]     tail_next;
  logic [CNT_W:0]       count_next_w;

  // Pointer advance by 0..2 with wrap at FL_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(FL_DEPTH)) s = s - (PTR_W+1)'(FL_DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // Grant decision, grant values and next-state computation.
  always_comb begin
    n_req        = 2'({1'b0, alloc_req_a} + {1'b0, alloc_req_b});
    alloc_ok     = (count >= CNT_W'(n_req));
    grant        = alloc_ok && (n_req != 2'd0);
    head_p1      = ptr_add(head, 2'd1);
    tail_p1      = ptr_add(tail, 2'd1);
    alloc_reg_a  = fifo[head];
    alloc_reg_b  = alloc_req_a ? fifo[head_p1] : fifo[head];

    // p0 is the hardwired zero register and never re-enters the pool.
    acc1         = free_in.valid1 && (free_in.reg1 != '0);
    acc2         = free_in.valid2 && (free_in.reg2 != '0);
    n_free       = 2'({1'b0, acc1} + {1'b0, acc2});
    wr0_en       = acc1 || acc2;
    wr1_en       = acc1 && acc2;
    wr0_reg      = acc1 ? free_in.reg1 : free_in.reg2;

    head_next    = grant ? ptr_add(head, n_req) : head;
    tail_next    = ptr_add(tail, n_free);
    count_next_w = (CNT_W+1)'(count) - (CNT_W+1)'(grant ? n_req : 2'd0) + (CNT_W+1)'(n_free);
  end

  // Storage, pointers and occupancy; synchronous reset refills p32..p63.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        fifo[i] <= PREG_BITS'(NUM_AREGS + i);
      end
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(FL_DEPTH);
    end else begin
      if (wr0_en) fifo[tail]    <= wr0_reg;
      if (wr1_en) fifo[tail_p1] <= free_in.reg2;
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next_w[CNT_W-1:0];
    end
  end

  // Protocol checks: overfilling the pool or freeing an out-of-range register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_next_w <= (CNT_W+1)'(FL_DEPTH))
        else $error("free_list: free into full pool");
      assert (!acc1 || (32'(free_in.reg1) < NUM_PREGS))
        else $error("free_list: reg1 out of range");
      assert (!acc2 || (32'(free_in.reg2) < NUM_PREGS))
        else $error("free_list: reg2 out of range");
    end
  end

  assign free_count = count;

endmodule
